// File: rtl/round_controller_pkg.sv
// Shared definitions for the binary math game: controller state encoding and
// game-wide defaults also used by the display and top-level game modules.
package round_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PLAY     = 3'd2,
        ST_CHECK    = 3'd3,
        ST_FEEDBACK = 3'd4,
        ST_OVER     = 3'd5
    } state_e;

    localparam int DEFAULT_ROUNDS          = 10;
    localparam int DEFAULT_FEEDBACK_CYCLES = 50_000_000;

    // States in which a Start edge begins a fresh game.
    function automatic logic accepts_start(input state_e s);
        return (s == ST_IDLE) || (s == ST_OVER);
    endfunction

endpackage

// File: rtl/round_controller_edge_pulse.sv
// One-bit rising-edge detector: pulse is high for the cycle in which din is
// high after being low on the previous cycle. History clears on reset.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_d;
    logic din_q;

    // Next value of the history flop is simply the current input level.
    always_comb begin
        din_d = din;
    end

    // History register for the previous-cycle input level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/round_controller.sv
// Game sequencer: starts rounds, drives the countdown timer, requests problems,
// grades submissions and keeps score. All outputs come straight from flops.
module round_controller
    import round_controller_pkg::*;
#(
    parameter int ROUNDS          = DEFAULT_ROUNDS,
    parameter int ROUND_W         = 4,
    parameter int SCORE_W         = 8,
    parameter int FEEDBACK_CYCLES = DEFAULT_FEEDBACK_CYCLES
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Submit,
    input  logic               Abort,
    input  logic               Correct,
    input  logic               TimeUp,
    output logic               TimerEnable,
    output logic               TimerReconfig,
    output logic               NewProblem,
    output logic               ResultValid,
    output logic               Hit,
    output logic [SCORE_W-1:0] Score,
    output logic [ROUND_W-1:0] Round,
    output logic               GameOver
);

    localparam int                 FB_W      = $clog2(FEEDBACK_CYCLES + 1);
    localparam logic [FB_W-1:0]    FB_LOAD   = FB_W'(FEEDBACK_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [ROUND_W:0]   ROUNDS_W  = (ROUND_W + 1)'(ROUNDS);

    logic start_edge_s;
    logic submit_edge_s;

    state_e             state_d,  state_q;
    logic [SCORE_W-1:0] score_d,  score_q;
    logic [ROUND_W-1:0] round_d,  round_q;
    logic [FB_W-1:0]    fb_cnt_d, fb_cnt_q;
    logic               hit_d,    hit_q;
    logic               timer_enable_d,   timer_enable_q;
    logic               timer_reconfig_d, timer_reconfig_q;
    logic               new_problem_d,    new_problem_q;
    logic               result_valid_d,   result_valid_q;
    logic               game_over_d,      game_over_q;
    logic [ROUND_W:0]   round_next_s;

    edge_pulse u_start_edge (
        .clk   (Clock),
        .rst_n (Reset),
        .din   (Start),
        .pulse (start_edge_s)
    );

    edge_pulse u_submit_edge (
        .clk   (Clock),
        .rst_n (Reset),
        .din   (Submit),
        .pulse (submit_edge_s)
    );

    // One extra bit so the final round of a 2**ROUND_W game is still detected.
    assign round_next_s = {1'b0, round_q} + (ROUND_W + 1)'(1);

    // Next-state, score/round bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        round_d  = round_q;
        fb_cnt_d = fb_cnt_q;
        hit_d    = hit_q;

        if (Abort) begin
            state_d  = ST_IDLE;
            score_d  = {SCORE_W{1'b0}};
            round_d  = {ROUND_W{1'b0}};
            fb_cnt_d = {FB_W{1'b0}};
            hit_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (accepts_start(state_q) && start_edge_s) begin
                        state_d = ST_LOAD;
                        score_d = {SCORE_W{1'b0}};
                        round_d = {ROUND_W{1'b0}};
                        hit_d   = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    // A timeout beats a same-cycle submission.
                    if (TimeUp) begin
                        state_d  = ST_FEEDBACK;
                        hit_d    = 1'b0;
                        fb_cnt_d = FB_LOAD;
                    end else if (submit_edge_s) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_CHECK: begin
                    state_d  = ST_FEEDBACK;
                    fb_cnt_d = FB_LOAD;
                    if (Correct) begin
                        hit_d = 1'b1;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SCORE_W'(1);
                        end else begin
                            score_d = score_q;
                        end
                    end else begin
                        hit_d = 1'b0;
                    end
                end
                ST_FEEDBACK: begin
                    if (fb_cnt_q == {FB_W{1'b0}}) begin
                        round_d = round_next_s[ROUND_W-1:0];
                        if (round_next_s == ROUNDS_W) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        fb_cnt_d = fb_cnt_q - FB_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        timer_enable_d   = (state_d == ST_PLAY);
        timer_reconfig_d = (state_d == ST_LOAD);
        new_problem_d    = (state_d == ST_LOAD);
        result_valid_d   = (state_d == ST_FEEDBACK);
        game_over_d      = (state_d == ST_OVER);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q          <= ST_IDLE;
            score_q          <= {SCORE_W{1'b0}};
            round_q          <= {ROUND_W{1'b0}};
            fb_cnt_q         <= {FB_W{1'b0}};
            hit_q            <= 1'b0;
            timer_enable_q   <= 1'b0;
            timer_reconfig_q <= 1'b0;
            new_problem_q    <= 1'b0;
            result_valid_q   <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            score_q          <= score_d;
            round_q          <= round_d;
            fb_cnt_q         <= fb_cnt_d;
            hit_q            <= hit_d;
            timer_enable_q   <= timer_enable_d;
            timer_reconfig_q <= timer_reconfig_d;
            new_problem_q    <= new_problem_d;
            result_valid_q   <= result_valid_d;
            game_over_q      <= game_over_d;
        end
    end

    assign TimerEnable   = timer_enable_q;
    assign TimerReconfig = timer_reconfig_q;
    assign NewProblem    = new_problem_q;
    assign ResultValid   = result_valid_q;
    assign Hit           = hit_q;
    assign Score         = score_q;
    assign Round         = round_q;
    assign GameOver      = game_over_q;

endmodule
